// File: rtl/ps_pkg.sv
// Shared constants and FSM encoding for the program sequencer.
// Optional return stack is enabled with PS_CALL_STACK_EN.
package ps_pkg;

   localparam int unsigned ADDR_W_DEF      = 8;
   localparam logic [7:0]  RESET_VECTOR_DEF = 8'h00;
   localparam int unsigned STACK_DEPTH_DEF = 4;

   typedef enum logic [1:0] {
      S_RESET = 2'd0,
      S_RUN   = 2'd1,
      S_HOLD  = 2'd2
   } ps_state_e;

endpackage

// File: rtl/program_sequencer_if.sv
// Decoder/datapath <-> sequencer signal bundle.
// call/ret/stack_err exist only with PS_CALL_STACK_EN.
interface program_sequencer_if #(
   parameter int unsigned ADDR_W = ps_pkg::ADDR_W_DEF
) ();

   logic              jmp;
   logic              jmp_nz;
   logic [ADDR_W-1:0] jmp_addr;
   logic              dont_jmp;
   logic              hold;
   logic [ADDR_W-1:0] pm_addr;
   logic [ADDR_W-1:0] pc;
   logic [1:0]        state;
   logic [7:0]        from_PS;
`ifdef PS_CALL_STACK_EN
   logic              call;
   logic              ret;
   logic              stack_err;
`endif

   modport master (
      output jmp, jmp_nz, jmp_addr, dont_jmp, hold,
`ifdef PS_CALL_STACK_EN
      output call, ret,
      input  stack_err,
`endif
      input  pm_addr, pc, state, from_PS
   );

   modport slave (
      input  jmp, jmp_nz, jmp_addr, dont_jmp, hold,
`ifdef PS_CALL_STACK_EN
      input  call, ret,
      output stack_err,
`endif
      output pm_addr, pc, state, from_PS
   );

endinterface

// File: rtl/ps_return_stack.sv
// LIFO of return addresses; overflowing pushes and underflowing pops are
// dropped and latch a sticky error until reset.
module ps_return_stack #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] push_data,
   output logic [W-1:0] top_c,
   output logic         full_c,
   output logic         empty_c,
   output logic         err
);

   localparam int unsigned PTR_W = $clog2(DEPTH + 1);
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     mem_d [DEPTH];
   logic [PTR_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   assign full_c  = (cnt_q == PTR_W'(DEPTH));
   assign empty_c = (cnt_q == '0);
   assign top_c   = mem_q[IDX_W'(cnt_q - PTR_W'(1))];
   assign err     = err_q;

   always_comb begin
      mem_d = mem_q;
      cnt_d = cnt_q;
      err_d = err_q;
      if (push) begin
         if (full_c) begin
            err_d = 1'b1;
         end else begin
            mem_d[IDX_W'(cnt_q)] = push_data;
            cnt_d = cnt_q + PTR_W'(1);
         end
      end else if (pop) begin
         if (empty_c) err_d = 1'b1;
         else         cnt_d = cnt_q - PTR_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q <= '{default: '0};
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         mem_q <= mem_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

endmodule

// File: rtl/program_sequencer.sv
// Program-memory address generator: increment, hold or branch each cycle.
// Define PS_CALL_STACK_EN to add call/ret through ps_return_stack.
module program_sequencer
   import ps_pkg::*;
#(
   parameter int unsigned       ADDR_W       = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEF)
`ifdef PS_CALL_STACK_EN
   ,
   parameter int unsigned       STACK_DEPTH  = STACK_DEPTH_DEF
`endif
) (
   input  logic                clk,
   input  logic                sync_reset,
   program_sequencer_if.slave  bus
);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] pm_addr_c;
   ps_state_e         state_q, state_d;
   logic [7:0]        br_cnt_q, br_cnt_d;

`ifdef PS_CALL_STACK_EN
   logic              stk_push, stk_pop;
   logic              stk_full, stk_empty;
   logic [ADDR_W-1:0] stk_top;

   ps_return_stack #(
      .W     (ADDR_W),
      .DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk       (clk),
      .rst       (sync_reset),
      .push      (stk_push),
      .pop       (stk_pop),
      .push_data (pc_inc),
      .top_c     (stk_top),
      .full_c    (stk_full),
      .empty_c   (stk_empty),
      .err       (bus.stack_err)
   );
`endif

   // Address select; S_HOLD shares the run priority so release resumes in the same cycle.
   always_comb begin
      pc_inc    = pc_q + ADDR_W'(1);
      pm_addr_c = RESET_VECTOR;
      state_d   = state_q;
      br_cnt_d  = br_cnt_q;
`ifdef PS_CALL_STACK_EN
      stk_push  = 1'b0;
      stk_pop   = 1'b0;
`endif
      case (state_q)
         S_RESET: begin
            state_d = S_RUN;
         end
         S_RUN, S_HOLD: begin
            if (bus.hold) begin
               pm_addr_c = pc_q;
               state_d   = S_HOLD;
            end else begin
               state_d = S_RUN;
               if (bus.jmp || (bus.jmp_nz && !bus.dont_jmp)) begin
                  pm_addr_c = bus.jmp_addr;
                  br_cnt_d  = br_cnt_q + 8'd1;
               end
`ifdef PS_CALL_STACK_EN
               else if (bus.call) begin
                  stk_push  = 1'b1;
                  pm_addr_c = stk_full ? pc_inc : bus.jmp_addr;
                  if (!stk_full) br_cnt_d = br_cnt_q + 8'd1;
               end else if (bus.ret) begin
                  stk_pop   = 1'b1;
                  pm_addr_c = stk_empty ? pc_inc : stk_top;
                  if (!stk_empty) br_cnt_d = br_cnt_q + 8'd1;
               end
`endif
               else begin
                  pm_addr_c = pc_inc;
               end
            end
         end
         default: begin
            state_d = S_RESET;
         end
      endcase
      pc_d = pm_addr_c;
   end

   always_ff @(posedge clk or posedge sync_reset) begin
      if (sync_reset) begin
         pc_q     <= RESET_VECTOR;
         state_q  <= S_RESET;
         br_cnt_q <= 8'd0;
      end else begin
         pc_q     <= pc_d;
         state_q  <= state_d;
         br_cnt_q <= br_cnt_d;
      end
   end

   assign bus.pm_addr = pm_addr_c;
   assign bus.pc      = pc_q;
   assign bus.state   = state_q;
   assign bus.from_PS = br_cnt_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer against a behavioural model.
// Exercises call/ret when built with PS_CALL_STACK_EN.
module tb_program_sequencer;

   logic clk;
   logic sync_reset;

   program_sequencer_if #(.ADDR_W(8)) bus ();

   program_sequencer #(
      .ADDR_W       (8),
      .RESET_VECTOR (8'h00)
   ) dut (
      .clk        (clk),
      .sync_reset (sync_reset),
      .bus        (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Model: phase 0 = reset cycle, 1 = running, 2 = held
   logic [7:0] m_pc;
   logic [7:0] m_cnt;
   logic [1:0] m_phase;
   logic [7:0] m_stack[$];
   logic       m_err;

   logic [7:0] e_pm;
   logic [1:0] e_phase;
   logic       e_taken, e_push, e_pop, e_err;

   task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %02h expected %02h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc    = 8'h00;
      m_cnt   = 8'h00;
      m_phase = 2'd0;
      m_err   = 1'b0;
      m_stack.delete();
   endtask

   task automatic model_eval(input logic j, jn, input logic [7:0] ja,
                             input logic dj, h, c, r);
      logic [7:0] nxt;
      nxt     = 8'(m_pc + 8'd1);
      e_taken = 1'b0;
      e_push  = 1'b0;
      e_pop   = 1'b0;
      e_err   = 1'b0;
      if (m_phase == 2'd0) begin
         e_pm = 8'h00;  e_phase = 2'd1;
      end else if (h) begin
         e_pm = m_pc;   e_phase = 2'd2;
      end else begin
         e_phase = 2'd1;
         if (j || (jn && !dj)) begin
            e_pm = ja;  e_taken = 1'b1;
         end else if (c) begin
            if (m_stack.size() >= 4) begin
               e_pm = nxt;  e_err = 1'b1;
            end else begin
               e_pm = ja;   e_push = 1'b1;  e_taken = 1'b1;
            end
         end else if (r) begin
            if (m_stack.size() == 0) begin
               e_pm = nxt;  e_err = 1'b1;
            end else begin
               e_pm = m_stack[$];  e_pop = 1'b1;  e_taken = 1'b1;
            end
         end else begin
            e_pm = nxt;
         end
      end
   endtask

   task automatic model_commit();
      if (e_push) m_stack.push_back(8'(m_pc + 8'd1));
      if (e_pop)  void'(m_stack.pop_back());
      if (e_err)  m_err = 1'b1;
      if (e_taken) m_cnt = 8'(m_cnt + 8'd1);
      m_pc    = e_pm;
      m_phase = e_phase;
   endtask

   task automatic check_regs(input string tag);
      check({tag, ".pc"}, bus.pc, m_pc);
      check({tag, ".state"}, 8'(bus.state), 8'(m_phase));
      check({tag, ".from_PS"}, bus.from_PS, m_cnt);
`ifdef PS_CALL_STACK_EN
      check({tag, ".stack_err"}, 8'(bus.stack_err), 8'(m_err));
`endif
   endtask

   // One clock: drive, check combinational address and registers, advance.
   task automatic cyc(input logic j, jn, input logic [7:0] ja,
                      input logic dj, h, c, r);
      bus.jmp      = j;
      bus.jmp_nz   = jn;
      bus.jmp_addr = ja;
      bus.dont_jmp = dj;
      bus.hold     = h;
`ifdef PS_CALL_STACK_EN
      bus.call     = c;
      bus.ret      = r;
`endif
      #1;
      model_eval(j, jn, ja, dj, h, c, r);
      check("pm_addr", bus.pm_addr, e_pm);
      check_regs("cyc");
      @(posedge clk);
      model_commit();
      #1;
   endtask

   // Assert reset mid-cycle with a branch pending, hold over an edge, release mid-cycle.
   task automatic do_reset();
      @(posedge clk);
      #2;
      bus.jmp      = 1'b1;
      bus.jmp_addr = 8'hA5;
      #1;
      sync_reset = 1'b1;
      #1;
      model_reset();
      check("rst.pm_addr", bus.pm_addr, 8'h00);
      check_regs("rst");
      @(posedge clk);
      #2;
      check("rst_hold.pm_addr", bus.pm_addr, 8'h00);
      sync_reset = 1'b0;
   endtask

   initial begin
      logic c_r, r_r;
      sync_reset   = 1'b1;
      bus.jmp      = 1'b0;
      bus.jmp_nz   = 1'b0;
      bus.jmp_addr = 8'h00;
      bus.dont_jmp = 1'b0;
      bus.hold     = 1'b0;
`ifdef PS_CALL_STACK_EN
      bus.call     = 1'b0;
      bus.ret      = 1'b0;
`endif
      model_reset();
      sync_reset   = 1'b0;

      // Reset then sequential fetch 00, 00, 01, 02, 03, 04, 05
      do_reset();
      for (int i = 0; i < 6; i++) cyc(0, 0, 8'h77, 0, 0, 0, 0);
      check("seq.pc", bus.pc, 8'h05);

      // Unconditional jump from 05
      cyc(1, 0, 8'h3C, 0, 0, 0, 0);
      check("jmp.pc", bus.pc, 8'h3C);
      check("jmp.cnt", bus.from_PS, 8'd1);

      // Conditional jump at pc 20, not taken then taken
      cyc(1, 0, 8'h20, 0, 0, 0, 0);
      cyc(0, 1, 8'h10, 1, 0, 0, 0);
      check("jnz_nt.pc", bus.pc, 8'h21);
      check("jnz_nt.cnt", bus.from_PS, 8'd2);
      cyc(0, 1, 8'h10, 0, 0, 0, 0);
      check("jnz_t.pc", bus.pc, 8'h10);
      check("jnz_t.cnt", bus.from_PS, 8'd3);

      // jmp and jmp_nz together: jmp target, single count
      cyc(1, 1, 8'h66, 0, 0, 0, 0);
      check("both.pc", bus.pc, 8'h66);
      check("both.cnt", bus.from_PS, 8'd4);

      // Hold at FE with jumps discarded, then wrap FF -> 00
      cyc(1, 0, 8'hFE, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(1, 1, 8'h55, 0, 1, 0, 0);
      check("hold.pc", bus.pc, 8'hFE);
      check("hold.state", 8'(bus.state), 8'd2);
      check("hold.cnt", bus.from_PS, 8'd5);
      cyc(0, 0, 8'h00, 0, 0, 0, 0);
      check("wrap1.pc", bus.pc, 8'hFF);
      cyc(0, 0, 8'h00, 0, 0, 0, 0);
      check("wrap2.pc", bus.pc, 8'h00);

`ifdef PS_CALL_STACK_EN
      do_reset();
      cyc(0, 0, 8'h00, 0, 0, 0, 0);
      cyc(1, 0, 8'h08, 0, 0, 0, 0);
      cyc(0, 0, 8'h40, 0, 0, 1, 0);
      check("call.pc", bus.pc, 8'h40);
      cyc(0, 0, 8'h00, 0, 0, 0, 1);
      check("ret.pc", bus.pc, 8'h09);
      for (int i = 0; i < 5; i++) cyc(0, 0, 8'(8'h80 + 8'(i * 16)), 0, 0, 1, 1);
      check("ovf.err", 8'(bus.stack_err), 8'd1);
      do_reset();
      cyc(0, 0, 8'h00, 0, 0, 0, 0);
      cyc(0, 0, 8'h00, 0, 0, 0, 1);
      check("unf.pc", bus.pc, 8'h01);
      check("unf.err", 8'(bus.stack_err), 8'd1);
`endif

      // Randomized traffic with occasional asynchronous resets
      for (int n = 0; n < 600; n++) begin
         if (n % 150 == 149) do_reset();
`ifdef PS_CALL_STACK_EN
         c_r = ($urandom % 6) == 0;
         r_r = ($urandom % 6) == 0;
`else
         c_r = 1'b0;
         r_r = 1'b0;
`endif
         cyc(($urandom % 8) == 0, ($urandom % 4) == 0, 8'($urandom),
             1'($urandom), ($urandom % 5) == 0, c_r, r_r);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
